// File: rtl/phi1_mul_stream.sv
// Forward Phi1 multiply: streams ternary m(x) in and emits (x-1)*m(x) mod (2^QW, x^N-1).
// Latency: each output is registered one cycle after the input fire that produces it; coeff 0 follows the wrap cycle.
// Backpressure: single output register; input is stalled while that register is full and not being drained.
module phi1_mul_stream #(
   parameter int N  = 701,
   parameter int QW = 13,
   parameter int IW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_coef,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [QW-1:0] out_coef,
   output logic [IW-1:0] out_idx,
   output logic          out_last,
   output logic          busy
);

   typedef enum logic [1:0] {S_FIRST, S_STREAM, S_WRAP} state_t;

   state_t        state;
   logic [IW-1:0] cnt;
   logic [1:0]    first;
   logic [1:0]    prev;
   logic          slot_free;
   logic          in_fire;
   logic          out_fire;

   // Ternary code to a 3-bit signed value; only bit0 carries magnitude, so 2'b10 reads as 0.
   function automatic logic [2:0] tern_val(input logic [1:0] c);
      logic [2:0] v;
      v = 3'b000;
      if (c[0]) begin
         v = c[1] ? 3'b111 : 3'b001;
      end
      return v;
   endfunction

   // a - b lies in -2..2, so a 3-bit signed difference is exact before sign extension.
   function automatic logic [QW-1:0] tern_sub(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] d;
      d = tern_val(a) - tern_val(b);
      return {{(QW-3){d[2]}}, d};
   endfunction

   assign slot_free = !out_valid || out_ready;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign busy      = (state != S_FIRST) || out_valid;

   // Input acceptance: the first coeff never produces output, so S_FIRST ignores the output slot.
   always_comb begin
      in_ready = 1'b0;
      case (state)
         S_FIRST:  in_ready = 1'b1;
         S_STREAM: in_ready = slot_free;
         default:  in_ready = 1'b0;
      endcase
   end

   // Frame sequencing and the single output register; a newly loaded output overrides the drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_FIRST;
         cnt       <= '0;
         first     <= 2'b00;
         prev      <= 2'b00;
         out_valid <= 1'b0;
         out_coef  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
      end else begin
         if (out_fire) begin
            out_valid <= 1'b0;
         end
         case (state)
            S_FIRST: begin
               if (in_fire) begin
                  first <= in_coef;
                  prev  <= in_coef;
                  cnt   <= IW'(1);
                  state <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (in_fire) begin
                  out_coef  <= tern_sub(prev, in_coef);
                  out_idx   <= cnt;
                  out_last  <= 1'b0;
                  out_valid <= 1'b1;
                  prev      <= in_coef;
                  if (cnt == IW'(N-1)) begin
                     state <= S_WRAP;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            S_WRAP: begin
               if (slot_free) begin
                  out_coef  <= tern_sub(prev, first);
                  out_idx   <= '0;
                  out_last  <= 1'b1;
                  out_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= S_FIRST;
               end
            end
            default: begin
               state <= S_FIRST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_phi1_mul_stream.sv
// Bench for phi1_mul_stream: a small N=5 instance for directed frames and an N=701 instance for random frames.
// Inputs and outputs are driven and sampled at the falling edge; every fire is logged into queues.
// Output hold under backpressure is checked whenever the previous cycle stalled.
module tb_phi1_mul_stream;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   // Cycle stamp used for latency and throughput checks.
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- N=5 instance ----------------
   logic        a_in_valid = 1'b0;
   logic        a_in_ready;
   logic [1:0]  a_in_coef = 2'b00;
   logic        a_out_valid;
   logic        a_out_ready = 1'b1;
   logic [12:0] a_out_coef;
   logic [9:0]  a_out_idx;
   logic        a_out_last;
   logic        a_busy;

   phi1_mul_stream #(.N(5), .QW(13), .IW(10)) u_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_coef(a_in_coef),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_coef(a_out_coef), .out_idx(a_out_idx), .out_last(a_out_last),
      .busy(a_busy)
   );

   // ---------------- N=701 instance ----------------
   logic        b_in_valid = 1'b0;
   logic        b_in_ready;
   logic [1:0]  b_in_coef = 2'b00;
   logic        b_out_valid;
   logic        b_out_ready = 1'b1;
   logic [12:0] b_out_coef;
   logic [9:0]  b_out_idx;
   logic        b_out_last;
   logic        b_busy;

   phi1_mul_stream #(.N(701), .QW(13), .IW(10)) u_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_coef(b_in_coef),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_coef(b_out_coef), .out_idx(b_out_idx), .out_last(b_out_last),
      .busy(b_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic int tv(input logic [1:0] c);
      return c[0] ? (c[1] ? -1 : 1) : 0;
   endfunction

   // Output records are {last, idx[9:0], coef[12:0]}.
   logic [1:0]  a_inq[$];
   logic [23:0] a_outq[$];
   int          a_in_cyc[$];
   int          a_out_cyc[$];
   bit          a_stall_en = 1'b0;
   int          a_stall_left = 0;
   bit          a_held = 1'b0;
   logic [23:0] a_prev = '0;

   logic [1:0]  b_inq[$];
   logic [23:0] b_outq[$];
   logic [23:0] b_expq[$];
   bit          b_rand = 1'b0;
   bit          b_held = 1'b0;
   logic [23:0] b_prev = '0;

   // Instance A driver/monitor: optional 3-cycle stall while idx 2 is presented.
   always @(negedge clk) begin
      if (a_held) chk("a_hold", {a_out_valid, a_out_last, a_out_idx, a_out_coef}, {1'b1, a_prev});
      a_out_ready = 1'b1;
      if (a_stall_en && a_out_valid && a_out_idx == 10'd2 && a_stall_left > 0) begin
         a_out_ready = 1'b0;
         a_stall_left--;
      end
      a_in_valid = (a_inq.size() > 0);
      a_in_coef  = (a_inq.size() > 0) ? a_inq[0] : 2'b00;
      #1;
      if (!a_out_ready) chk("t3_in_ready_low", a_in_ready, 0);
      if (a_in_valid && a_in_ready) begin
         void'(a_inq.pop_front());
         a_in_cyc.push_back(cyc);
      end
      a_held = a_out_valid && !a_out_ready;
      a_prev = {a_out_last, a_out_idx, a_out_coef};
      if (a_out_valid && a_out_ready) begin
         a_outq.push_back({a_out_last, a_out_idx, a_out_coef});
         a_out_cyc.push_back(cyc);
      end
   end

   // Instance B driver/monitor: random input gaps and random output backpressure.
   always @(negedge clk) begin
      if (b_held) chk("b_hold", {b_out_valid, b_out_last, b_out_idx, b_out_coef}, {1'b1, b_prev});
      b_out_ready = b_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      b_in_valid  = (b_inq.size() > 0) && (!b_rand || $urandom_range(0, 3) != 0);
      b_in_coef   = (b_inq.size() > 0) ? b_inq[0] : 2'b00;
      #1;
      if (b_in_valid && b_in_ready) void'(b_inq.pop_front());
      b_held = b_out_valid && !b_out_ready;
      b_prev = {b_out_last, b_out_idx, b_out_coef};
      if (b_out_valid && b_out_ready) b_outq.push_back({b_out_last, b_out_idx, b_out_coef});
   end

   task automatic wait_a(input int n);
      int b = 0;
      while (a_outq.size() < n && b < 200) begin
         @(negedge clk);
         b++;
      end
      if (a_outq.size() < n) chk("a_out_timeout", a_outq.size(), n);
   endtask

   task automatic clear_a();
      repeat (2) @(negedge clk);
      a_outq.delete();
      a_in_cyc.delete();
      a_out_cyc.delete();
   endtask

   logic [1:0]  t1m[5];
   logic [1:0]  t4m[5];
   logic [23:0] t1e[5];
   logic [23:0] t4e[5];
   logic [1:0]  fr[701];
   logic [12:0] s;

   task automatic push_a(input logic [1:0] m[5]);
      for (int i = 0; i < 5; i++) a_inq.push_back(m[i]);
   endtask

   task automatic check_t1(input string tag);
      for (int i = 0; i < 5; i++) begin
         if (i < a_outq.size()) chk($sformatf("%s_out%0d", tag, i), a_outq[i], t1e[i]);
      end
   endtask

   initial begin
      t1m = '{2'b01, 2'b00, 2'b11, 2'b01, 2'b00};
      t1e = '{{1'b0, 10'd1, 13'h0001}, {1'b0, 10'd2, 13'h0001}, {1'b0, 10'd3, 13'h1FFE},
              {1'b0, 10'd4, 13'h0001}, {1'b1, 10'd0, 13'h1FFF}};
      // values -1,+1,0(illegal 10),0,-1
      t4m = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11};
      t4e = '{{1'b0, 10'd1, 13'h1FFE}, {1'b0, 10'd2, 13'h0001}, {1'b0, 10'd3, 13'h0000},
              {1'b0, 10'd4, 13'h0001}, {1'b1, 10'd0, 13'h0000}};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #2;
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_out_coef", a_out_coef, 0);
      chk("rst_out_idx", a_out_idx, 0);
      chk("rst_out_last", a_out_last, 0);
      chk("rst_in_ready", a_in_ready, 1);

      // T1: basic frame, latency and throughput
      push_a(t1m);
      wait_a(5);
      chk("t1_count", a_outq.size(), 5);
      check_t1("t1");
      if (a_in_cyc.size() == 5 && a_out_cyc.size() == 5) begin
         chk("t1_latency", a_out_cyc[0] - a_in_cyc[1], 1);
         chk("t1_in_rate", a_in_cyc[4] - a_in_cyc[0], 4);
         chk("t1_wrap_cycle", a_out_cyc[4] - a_in_cyc[4], 2);
      end
      clear_a();

      // T2: all-zero frame, busy drops after the last output
      for (int i = 0; i < 5; i++) a_inq.push_back(2'b00);
      wait_a(5);
      #2;
      chk("t2_busy_after", a_busy, 0);
      for (int i = 0; i < 5; i++) begin
         if (i < a_outq.size())
            chk($sformatf("t2_out%0d", i), a_outq[i], {(i == 4), 10'((i + 1) % 5), 13'h0000});
      end
      clear_a();

      // T3: stall three cycles while idx 2 is presented
      a_stall_en = 1'b1;
      a_stall_left = 3;
      push_a(t1m);
      wait_a(5);
      chk("t3_count", a_outq.size(), 5);
      check_t1("t3");
      chk("t3_stall_seen", a_stall_left, 0);
      a_stall_en = 1'b0;
      clear_a();

      // T4: back-to-back frames, next m0 taken right after the wrap output loads
      push_a(t1m);
      push_a(t4m);
      wait_a(10);
      chk("t4_count", a_outq.size(), 10);
      check_t1("t4a");
      for (int i = 0; i < 5; i++) begin
         if (i + 5 < a_outq.size()) chk($sformatf("t4b_out%0d", i), a_outq[i + 5], t4e[i]);
      end
      if (a_in_cyc.size() == 10) chk("t4_gap", a_in_cyc[5] - a_in_cyc[4], 2);
      clear_a();

      // T5: reset after three inputs, then a clean frame
      for (int i = 0; i < 3; i++) a_inq.push_back(t1m[i]);
      begin
         int b = 0;
         while (a_inq.size() > 0 && b < 50) begin
            @(negedge clk);
            b++;
         end
         if (a_inq.size() > 0) chk("t5_in_timeout", a_inq.size(), 0);
      end
      #2;
      chk("t5_busy_mid", a_busy, 1);
      rst = 1'b1;
      @(negedge clk);
      #2;
      chk("t5_rst_out_valid", a_out_valid, 0);
      chk("t5_rst_busy", a_busy, 0);
      rst = 1'b0;
      clear_a();
      push_a(t1m);
      wait_a(5);
      chk("t5_count", a_outq.size(), 5);
      check_t1("t5");
      clear_a();

      // T6: three random N=701 frames including the illegal code, random backpressure
      b_rand = 1'b1;
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 701; k++) begin
            fr[k] = 2'($urandom_range(0, 3));
            b_inq.push_back(fr[k]);
         end
         for (int k = 1; k < 701; k++)
            b_expq.push_back({1'b0, 10'(k), 13'(tv(fr[k-1]) - tv(fr[k]))});
         b_expq.push_back({1'b1, 10'd0, 13'(tv(fr[700]) - tv(fr[0]))});
      end
      begin
         int b = 0;
         while (b_outq.size() < b_expq.size() && b < 20000) begin
            @(negedge clk);
            b++;
         end
      end
      chk("t6_count", b_outq.size(), b_expq.size());
      for (int i = 0; i < b_expq.size(); i++) begin
         if (i < b_outq.size()) chk($sformatf("t6_out%0d", i), b_outq[i], b_expq[i]);
      end
      if (b_outq.size() == 3 * 701) begin
         for (int f = 0; f < 3; f++) begin
            s = '0;
            for (int k = 0; k < 701; k++) s = s + b_outq[f * 701 + k][12:0];
            chk($sformatf("t6_sum%0d", f), s, 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
